// File: rtl/alarm_ctrl_fsm_pkg.sv
// Shared definitions for the alarm clock keypad sequencer: state encodings and keypad constants.
package alarm_ctrl_fsm_pkg;

    typedef enum logic [2:0] {
        SHOW_TIME        = 3'd0,
        KEY_STORED       = 3'd1,
        KEY_WAITED       = 3'd2,
        KEY_ENTRY        = 3'd3,
        SHOW_ALARM       = 3'd4,
        SET_ALARM_TIME   = 3'd5,
        SET_CURRENT_TIME = 3'd6
    } state_t;

    localparam logic [3:0] NOKEY_DEFAULT = 4'd10;
    localparam logic [2:0] DIGIT_MAX     = 3'd4;

    // The states in which the operator is mid-entry and the inactivity clock runs.
    function automatic logic is_entry(input state_t s);
        return (s == KEY_WAITED) || (s == KEY_ENTRY);
    endfunction

endpackage

// File: rtl/alarm_ctrl_fsm_inactivity_timer.sv
// Purpose: counts one_second ticks while enabled; flags the tick that completes TIMEOUT_S seconds.
// Latency: timeout is combinational on the completing tick; count registered.
// Backpressure: none; saturates at TIMEOUT_S-1 and holds until cleared.
module inactivity_timer #(
    parameter int TIMEOUT_S = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic one_second,
    output logic timeout
);

    localparam int            CW   = $clog2(TIMEOUT_S);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_S - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && one_second && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign timeout = enable && one_second && (count == LAST);

endmodule

// File: rtl/alarm_ctrl_fsm.sv
// Purpose: keypad/button sequencer driving the keyreg digit buffer; optional KEY_DIGIT_LIMIT_EN caps entry at 4 digits.
// Latency: every output is registered, 1 cycle after the input that causes it.
// Backpressure: none; a held key yields one shift, further input waits for key release.
module alarm_ctrl_fsm
    import alarm_ctrl_fsm_pkg::*;
#(
    parameter int         TIMEOUT_S = 10,
    parameter logic [3:0] NOKEY     = NOKEY_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_second,
    input  logic [3:0] key,
    input  logic       alarm_button,
    input  logic       time_button,
    output logic       shift,
    output logic       load_new_a,
    output logic       load_new_c,
    output logic       show_new_time,
    output logic       show_a
);

    state_t state;
    state_t nxt;
    logic   timeout;
    logic   key_vld;
    logic   btn_ok;
    logic   key_ok;

    inactivity_timer #(.TIMEOUT_S(TIMEOUT_S)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      ((state == SHOW_TIME) || (state == KEY_STORED)),
        .enable     (is_entry(state)),
        .one_second (one_second),
        .timeout    (timeout)
    );

    assign key_vld = (key != NOKEY);

`ifdef KEY_DIGIT_LIMIT_EN
    logic [2:0] digits;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digits <= '0;
        end else if (state == SHOW_TIME) begin
            digits <= '0;
        end else if ((state == KEY_STORED) && (digits != DIGIT_MAX)) begin
            digits <= digits + 3'd1;
        end
    end

    // A full buffer is the only thing the set buttons may commit.
    assign btn_ok = (digits == DIGIT_MAX);
    assign key_ok = (digits != DIGIT_MAX);
`else
    assign btn_ok = 1'b1;
    assign key_ok = 1'b1;
`endif

    always_comb begin
        nxt = state;
        case (state)
            SHOW_TIME: begin
                if (alarm_button)  nxt = SHOW_ALARM;
                else if (key_vld)  nxt = KEY_STORED;
            end
            KEY_STORED:            nxt = KEY_WAITED;
            KEY_WAITED: begin
                if (!key_vld)      nxt = KEY_ENTRY;
                else if (timeout)  nxt = SHOW_TIME;
            end
            KEY_ENTRY: begin
                if (btn_ok && alarm_button)     nxt = SET_ALARM_TIME;
                else if (btn_ok && time_button) nxt = SET_CURRENT_TIME;
                else if (key_ok && key_vld)     nxt = KEY_STORED;
                else if (timeout)               nxt = SHOW_TIME;
            end
            SHOW_ALARM: begin
                if (!alarm_button) nxt = SHOW_TIME;
            end
            SET_ALARM_TIME:        nxt = SHOW_TIME;
            SET_CURRENT_TIME:      nxt = SHOW_TIME;
            default:               nxt = SHOW_TIME;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= SHOW_TIME;
            shift         <= 1'b0;
            load_new_a    <= 1'b0;
            load_new_c    <= 1'b0;
            show_new_time <= 1'b0;
            show_a        <= 1'b0;
        end else begin
            state         <= nxt;
            shift         <= (nxt == KEY_STORED);
            load_new_a    <= (nxt == SET_ALARM_TIME);
            load_new_c    <= (nxt == SET_CURRENT_TIME);
            show_new_time <= is_entry(nxt);
            show_a        <= (nxt == SHOW_ALARM);
        end
    end

endmodule
